// File: rtl/audio_sequencer_pkg.sv
// Shared definitions for the audio sequencer: command word field positions and FSM states.
// The field layout is shared with the MMIO decoder and firmware headers.
package audio_sequencer_pkg;

    localparam int DLY_MSB = 31;
    localparam int DLY_LSB = 20;
    localparam int CH_MSB  = 19;
    localparam int CH_LSB  = 18;
    localparam int PV_BIT  = 17;
    localparam int VAL_MSB = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_ISSUE = 2'd3
    } seq_state_t;

    function automatic logic [31:0] zext_value(input logic [31:0] cmd);
        return {15'b0, cmd[VAL_MSB:0]};
    endfunction

endpackage

// File: rtl/audio_sequencer_sync_fifo.sv
// Single-clock FIFO holding queued note commands; clear empties it in one cycle.
// A push when full is accepted only if a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/audio_sequencer.sv
// Timed command scheduler and sole owner of the audio-unit write port.
// state | meaning
// IDLE  | nothing in flight, waiting for enable and a queued command
// FETCH | pop head of FIFO and latch its fields
// WAIT  | count delay ticks (frozen while enable=0)
// ISSUE | drive the latched command onto the audio-unit write port for one cycle
module audio_sequencer
    import audio_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int TICK_DIV    = 50000,
    parameter int DELAY_WIDTH = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          flush,
    input  logic [31:0]                   cmd_wdata,
    input  logic                          cmd_push,
    output logic                          cmd_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overflow,
    input  logic [1:0]                    cpu_channel_sel,
    input  logic                          cpu_pv_sel,
    input  logic [31:0]                   cpu_wdata,
    input  logic                          cpu_wenable,
    output logic                          cpu_wready,
    output logic [1:0]                    au_channel_sel,
    output logic                          au_pv_sel,
    output logic [31:0]                   au_wdata,
    output logic                          au_wenable
);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    seq_state_t             state;
    logic [TICK_W-1:0]      tick_cnt;
    logic [DELAY_WIDTH-1:0] delay_cnt;
    logic [1:0]             cmd_ch;
    logic                   cmd_pv;
    logic [31:0]            cmd_value;

    logic [31:0]            fifo_rdata;
    logic                   fifo_empty;
    logic                   pop;
    logic                   issue_now;
    logic [DELAY_WIDTH-1:0] head_delay;

    assign pop        = (state == S_FETCH);
    assign head_delay = DELAY_WIDTH'(fifo_rdata[DLY_MSB:DLY_LSB]);
    assign busy       = (state != S_IDLE);
    // flush steals the ISSUE slot back for the CPU so no partial sequencer write leaks out
    assign issue_now  = (state == S_ISSUE) && !flush;
    assign cpu_wready = !issue_now;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (cmd_push && !flush),
        .pop   (pop),
        .wdata (cmd_wdata),
        .rdata (fifo_rdata),
        .full  (cmd_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        au_channel_sel = cpu_channel_sel;
        au_pv_sel      = cpu_pv_sel;
        au_wdata       = cpu_wdata;
        au_wenable     = cpu_wenable;
        if (issue_now) begin
            au_channel_sel = cmd_ch;
            au_pv_sel      = cmd_pv;
            au_wdata       = cmd_value;
            au_wenable     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            delay_cnt <= '0;
            cmd_ch    <= '0;
            cmd_pv    <= 1'b0;
            cmd_value <= '0;
            overflow  <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            delay_cnt <= '0;
            cmd_ch    <= '0;
            cmd_pv    <= 1'b0;
            cmd_value <= '0;
            overflow  <= 1'b0;
        end else begin
            if (cmd_push && cmd_full && !pop) overflow <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (enable && !fifo_empty) state <= S_FETCH;
                end
                S_FETCH: begin
                    cmd_ch    <= fifo_rdata[CH_MSB:CH_LSB];
                    cmd_pv    <= fifo_rdata[PV_BIT];
                    cmd_value <= zext_value(fifo_rdata);
                    tick_cnt  <= '0;
                    delay_cnt <= head_delay;
                    state     <= (head_delay == '0) ? S_ISSUE : S_WAIT;
                end
                S_WAIT: begin
                    if (enable) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt  <= '0;
                            delay_cnt <= delay_cnt - DELAY_WIDTH'(1);
                            if (delay_cnt == DELAY_WIDTH'(1)) state <= S_ISSUE;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    state <= (enable && !fifo_empty) ? S_FETCH : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_sequencer.sv
// Self-checking bench for audio_sequencer (TICK_DIV=4): table-driven arbitration vectors,
// hand-timed corner sequences, and random traffic against a queue-based reference model.
module tb_audio_sequencer;
    localparam int TD = 4;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        flush;
    logic [31:0] cmd_wdata;
    logic        cmd_push;
    logic        cmd_full;
    logic [4:0]  fifo_count;
    logic        busy;
    logic        overflow;
    logic [1:0]  cpu_channel_sel;
    logic        cpu_pv_sel;
    logic [31:0] cpu_wdata;
    logic        cpu_wenable;
    logic        cpu_wready;
    logic [1:0]  au_channel_sel;
    logic        au_pv_sel;
    logic [31:0] au_wdata;
    logic        au_wenable;

    int n_cmp = 0;
    int n_err = 0;

    audio_sequencer #(
        .FIFO_DEPTH  (16),
        .TICK_DIV    (TD),
        .DELAY_WIDTH (12)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .flush           (flush),
        .cmd_wdata       (cmd_wdata),
        .cmd_push        (cmd_push),
        .cmd_full        (cmd_full),
        .fifo_count      (fifo_count),
        .busy            (busy),
        .overflow        (overflow),
        .cpu_channel_sel (cpu_channel_sel),
        .cpu_pv_sel      (cpu_pv_sel),
        .cpu_wdata       (cpu_wdata),
        .cpu_wenable     (cpu_wenable),
        .cpu_wready      (cpu_wready),
        .au_channel_sel  (au_channel_sel),
        .au_pv_sel       (au_pv_sel),
        .au_wdata        (au_wdata),
        .au_wenable      (au_wenable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 0; flush = 0; cmd_wdata = 0; cmd_push = 0;
        cpu_channel_sel = 0; cpu_pv_sel = 0; cpu_wdata = 0; cpu_wenable = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic push_word(input logic [31:0] w);
        cmd_wdata = w;
        cmd_push  = 1'b1;
        next_cycle();
        cmd_push  = 1'b0;
    endtask

    function automatic logic [31:0] mk_cmd(input int dly, input int ch, input bit pv, input int val);
        return {12'(dly), 2'(ch), pv, 17'(val)};
    endfunction

    // Counts cycles from the push edge until the first au_wenable; enable dropped for a window.
    task automatic wait_write(input int max_cyc, input int pause_at, input int pause_len,
                              output int cyc, output bit seen);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < max_cyc) begin
            enable = !(cyc >= pause_at && cyc < pause_at + pause_len);
            @(negedge clk);
            if (au_wenable) seen = 1;
            else begin
                next_cycle();
                cyc++;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  ch;
        logic        pv;
        logic [31:0] wd;
        logic        we;
        logic [35:0] exp_au;
        logic        exp_rdy;
    } vec_t;

    // Reference model: queue of pending words plus an abstract phase and remaining-cycle budget.
    logic [31:0] m_q[$];
    int          m_phase;
    int          m_rem;
    logic [31:0] m_cmd;
    bit          m_ovf;

    function automatic logic [63:0] model_expect();
        bit          iss;
        logic [63:0] v;
        iss = (m_phase == 3) && !flush;
        v = 0;
        v[44]    = iss ? 1'b1 : cpu_wenable;
        v[43:42] = iss ? m_cmd[19:18] : cpu_channel_sel;
        v[41]    = iss ? m_cmd[17] : cpu_pv_sel;
        v[40:9]  = iss ? {15'b0, m_cmd[16:0]} : cpu_wdata;
        v[8]     = !iss;
        v[7]     = (m_phase != 0);
        v[6]     = (m_q.size() == 16);
        v[5:1]   = 5'(m_q.size());
        v[0]     = m_ovf;
        return v;
    endfunction

    task automatic model_step();
        int sz;
        bit popped;
        sz     = m_q.size();
        popped = (m_phase == 1);
        if (flush) begin
            m_q.delete();
            m_phase = 0; m_rem = 0; m_cmd = 0; m_ovf = 0;
        end else begin
            case (m_phase)
                0: if (enable && sz > 0) m_phase = 1;
                1: begin
                    if (sz == 0) m_phase = 0;
                    else begin
                        m_cmd = m_q[0];
                        if (m_cmd[31:20] == 0) m_phase = 3;
                        else begin
                            m_phase = 2;
                            m_rem   = int'(m_cmd[31:20]) * TD;
                        end
                    end
                end
                2: if (enable) begin
                    m_rem--;
                    if (m_rem == 0) m_phase = 3;
                end
                default: m_phase = (enable && sz > 0) ? 1 : 0;
            endcase
            if (popped && sz > 0) void'(m_q.pop_front());
            if (cmd_push) begin
                if (sz < 16 || popped) m_q.push_back(cmd_wdata);
                else m_ovf = 1;
            end
        end
    endtask

    initial begin
        int   cyc;
        bit   seen;
        int   writes;
        vec_t vecs[6];

        do_reset();

        // Reset state
        @(negedge clk);
        chk("reset_count", 64'(fifo_count), 64'd0);
        chk("reset_flags", {61'd0, busy, overflow, cmd_full}, 64'd0);
        chk("reset_port", {62'd0, au_wenable, cpu_wready}, 64'b01);
        next_cycle();

        // Arbitration table in IDLE: CPU path straight through
        vecs[0] = '{2'd0, 1'b0, 32'h0000_0000, 1'b0, {2'd0, 1'b0, 32'h0000_0000, 1'b0}, 1'b1};
        vecs[1] = '{2'd1, 1'b1, 32'h1234_5678, 1'b1, {2'd1, 1'b1, 32'h1234_5678, 1'b1}, 1'b1};
        vecs[2] = '{2'd2, 1'b0, 32'hFFFF_FFFF, 1'b1, {2'd2, 1'b0, 32'hFFFF_FFFF, 1'b1}, 1'b1};
        vecs[3] = '{2'd3, 1'b1, 32'h8000_0001, 1'b0, {2'd3, 1'b1, 32'h8000_0001, 1'b0}, 1'b1};
        vecs[4] = '{2'd3, 1'b0, 32'hA5A5_5A5A, 1'b1, {2'd3, 1'b0, 32'hA5A5_5A5A, 1'b1}, 1'b1};
        vecs[5] = '{2'd0, 1'b1, 32'h0001_FFFF, 1'b1, {2'd0, 1'b1, 32'h0001_FFFF, 1'b1}, 1'b1};
        for (int i = 0; i < 6; i++) begin
            cpu_channel_sel = vecs[i].ch;
            cpu_pv_sel      = vecs[i].pv;
            cpu_wdata       = vecs[i].wd;
            cpu_wenable     = vecs[i].we;
            @(negedge clk);
            chk($sformatf("table%0d", i),
                {27'd0, au_channel_sel, au_pv_sel, au_wdata, au_wenable, cpu_wready},
                {27'd0, vecs[i].exp_au, vecs[i].exp_rdy});
            next_cycle();
        end
        cpu_wenable = 0; cpu_channel_sel = 0; cpu_pv_sel = 0; cpu_wdata = 0;

        // 1: delay 0 command, write 2 cycles after push
        enable = 1;
        push_word(32'h0000_0100);
        wait_write(40, 1000, 0, cyc, seen);
        chk("t1_seen", 64'(seen), 64'd1);
        chk("t1_latency", 64'(cyc), 64'd2);
        chk("t1_port", {29'd0, au_channel_sel, au_pv_sel, au_wdata}, {29'd0, 2'd0, 1'b0, 32'h100});
        next_cycle();
        @(negedge clk);
        chk("t1_single", {62'd0, au_wenable, busy}, 64'd0);
        next_cycle();

        // 2: delay 3, ch2 volume, then same with a 5-cycle pause mid-WAIT
        push_word(mk_cmd(3, 2, 1'b1, 'h80));
        wait_write(60, 1000, 0, cyc, seen);
        chk("t2_latency", 64'(cyc), 64'd14);
        chk("t2_port", {29'd0, au_channel_sel, au_pv_sel, au_wdata}, {29'd0, 2'd2, 1'b1, 32'h80});
        next_cycle();
        next_cycle();
        push_word(mk_cmd(3, 2, 1'b1, 'h80));
        wait_write(60, 6, 5, cyc, seen);
        chk("t2_pause_latency", 64'(cyc), 64'd19);
        enable = 1;
        next_cycle();
        next_cycle();

        // 3: overfill with enable low, then flush
        enable = 0;
        for (int i = 0; i < 16; i++) push_word(mk_cmd(0, 0, 1'b0, i));
        @(negedge clk);
        chk("t3_full16", {58'd0, cmd_full, overflow, fifo_count}, {58'd0, 1'b1, 1'b0, 5'd16});
        next_cycle();
        push_word(mk_cmd(0, 1, 1'b0, 'h77));
        @(negedge clk);
        chk("t3_overflow", {58'd0, cmd_full, overflow, fifo_count}, {58'd0, 1'b1, 1'b1, 5'd16});
        next_cycle();
        flush = 1;
        next_cycle();
        flush = 0;
        enable = 1;
        writes = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) chk("t3_flushed", {58'd0, cmd_full, overflow, fifo_count}, 64'd0);
            if (au_wenable) writes++;
            next_cycle();
        end
        chk("t3_no_writes", 64'(writes), 64'd0);

        // 4: CPU request held across a sequencer ISSUE
        cpu_channel_sel = 2'd3; cpu_pv_sel = 1'b1; cpu_wdata = 32'hDEAD_BEEF; cpu_wenable = 1;
        push_word(mk_cmd(0, 1, 1'b0, 'h1ABCD));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 2)
                chk("t4_issue", {28'd0, au_wenable, cpu_wready, au_channel_sel, au_pv_sel, au_wdata},
                    {28'd0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0001_ABCD});
            else
                chk($sformatf("t4_cpu%0d", c),
                    {28'd0, au_wenable, cpu_wready, au_channel_sel, au_pv_sel, au_wdata},
                    {28'd0, 1'b1, 1'b1, 2'd3, 1'b1, 32'hDEAD_BEEF});
            next_cycle();
        end
        cpu_wenable = 0; cpu_channel_sel = 0; cpu_pv_sel = 0; cpu_wdata = 0;
        next_cycle();

        // 5a: flush mid-WAIT
        push_word(mk_cmd(2, 1, 1'b0, 'h55));
        repeat (5) next_cycle();
        @(negedge clk);
        chk("t5_in_wait", 64'(busy), 64'd1);
        flush = 1;
        next_cycle();
        flush = 0;
        writes = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 0) chk("t5_wait_idle", 64'(busy), 64'd0);
            if (au_wenable) writes++;
            next_cycle();
        end
        chk("t5_wait_no_write", 64'(writes), 64'd0);

        // 5b: flush during ISSUE hands the port to the CPU
        push_word(mk_cmd(0, 1, 1'b1, 'h33));
        next_cycle();
        next_cycle();
        flush = 1; cpu_wenable = 1; cpu_channel_sel = 2'd2; cpu_pv_sel = 0; cpu_wdata = 32'h0000_55AA;
        @(negedge clk);
        chk("t5_issue_flush", {28'd0, au_wenable, cpu_wready, au_channel_sel, au_pv_sel, au_wdata},
            {28'd0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_55AA});
        next_cycle();
        flush = 0; cpu_wenable = 0;
        @(negedge clk);
        chk("t5_issue_idle", {62'd0, busy, au_wenable}, 64'd0);
        next_cycle();

        // 6: async reset mid-WAIT
        push_word(mk_cmd(3, 0, 1'b0, 'h11));
        push_word(mk_cmd(3, 1, 1'b0, 'h22));
        repeat (5) next_cycle();
        @(negedge clk);
        chk("t6_pre", {58'd0, busy, fifo_count}, {58'd0, 1'b1, 5'd1});
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async", {56'd0, busy, overflow, cmd_full, fifo_count, au_wenable, cpu_wready},
            {56'd0, 3'b000, 5'd0, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        writes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (au_wenable) writes++;
            next_cycle();
        end
        chk("t6_no_write", 64'(writes), 64'd0);

        // Random traffic against the reference model
        do_reset();
        m_q.delete();
        m_phase = 0; m_rem = 0; m_cmd = 0; m_ovf = 0;
        for (int c = 0; c < 1500; c++) begin
            enable          = ($urandom % 8) != 0;
            cmd_push        = ($urandom % 3) == 0;
            cmd_wdata       = {12'($urandom_range(0, 2)), 2'($urandom), 1'($urandom), 17'($urandom)};
            flush           = ($urandom % 50) == 0;
            cpu_wenable     = 1'($urandom);
            cpu_channel_sel = 2'($urandom);
            cpu_pv_sel      = 1'($urandom);
            cpu_wdata       = $urandom;
            @(negedge clk);
            chk("rand",
                {19'd0, au_wenable, au_channel_sel, au_pv_sel, au_wdata, cpu_wready, busy,
                 cmd_full, fifo_count, overflow},
                model_expect());
            model_step();
            next_cycle();
        end
        enable = 0; cmd_push = 0; flush = 0; cpu_wenable = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
